// File: rtl/izh_pkg.sv
// Shared types and default constants for the Izhikevich neuron receive path.
package izh_pkg;

   localparam int unsigned       IZH_ISI_W = 12;
   localparam logic signed [7:0] IZH_TH_HI = 8'sh38;   // +0.875 in signed 2.6
   localparam logic signed [7:0] IZH_TH_LO = 8'shE0;   // -0.5 in signed 2.6

   typedef enum logic {
      ST_ARMED = 1'b0,
      ST_FIRED = 1'b1
   } dec_state_e;

   typedef struct packed {
      logic                 first;
      logic                 burst;
      logic [IZH_ISI_W-1:0] isi;
   } spike_event_t;

endpackage

// File: rtl/izh_event_fifo.sv
// Synchronous first-word-fall-through FIFO for spike events; a push into a full
// queue is accepted only when a pop happens in the same cycle.
module izh_event_fifo #(
   parameter int unsigned WIDTH = 14,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             full_o,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      do_pop  = pop_i && (cnt_q != '0);
      do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);
   end

   // Storage is cleared on reset so the head fields read zero while empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_q <= rd_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign data_o  = mem_q[rd_q];
   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/izh_spike_decoder.sv
// Spike detector with hysteresis, inter-spike interval measurement, burst
// flagging and a small event queue drained over valid/ready.
module izh_spike_decoder
   import izh_pkg::*;
#(
   parameter logic signed [7:0] TH_HI      = IZH_TH_HI,
   parameter logic signed [7:0] TH_LO      = IZH_TH_LO,
   parameter int unsigned       ISI_W      = IZH_ISI_W,
   parameter int unsigned       BURST_ISI  = 16,
   parameter int unsigned       FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_en,
   input  logic signed [7:0] v_in,
   output logic              spike_pulse,
   output logic              ev_valid,
   input  logic              ev_ready,
   output logic [ISI_W-1:0]  ev_isi,
   output logic              ev_burst,
   output logic              ev_first,
   output logic [7:0]        spike_count,
   output logic              overflow
);

   localparam logic [ISI_W-1:0] ISI_MAX = '1;
   localparam int unsigned      EV_W    = ISI_W + 2;

   dec_state_e       state_q;
   logic [ISI_W-1:0] isi_q;
   logic             first_q;
   logic             pulse_q;
   logic [7:0]       count_q;
   logic             ovf_q;

   logic             spike;
   logic             rearm;
   logic [ISI_W-1:0] ev_isi_d;
   logic             ev_burst_d;
   logic [EV_W-1:0]  push_data;
   logic [EV_W-1:0]  head_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;

   always_comb begin
      spike      = sample_en && (state_q == ST_ARMED) && (v_in >= TH_HI);
      rearm      = sample_en && (state_q == ST_FIRED) && (v_in <= TH_LO);
      // The spike sample itself is counted in the interval.
      ev_isi_d   = (isi_q == ISI_MAX) ? ISI_MAX : isi_q + 1'b1;
      ev_burst_d = !first_q && (32'(ev_isi_d) <= BURST_ISI);
      push_data  = {first_q, ev_burst_d, ev_isi_d};
      pop        = !fifo_empty && ev_ready;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_ARMED;
         isi_q   <= '0;
         first_q <= 1'b1;
         pulse_q <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         pulse_q <= spike;
         if (spike) begin
            state_q <= ST_FIRED;
            isi_q   <= '0;
            first_q <= 1'b0;
            if (count_q != 8'hFF) begin
               count_q <= count_q + 1'b1;
            end
         end else if (sample_en) begin
            if (rearm) begin
               state_q <= ST_ARMED;
            end
            if (isi_q != ISI_MAX) begin
               isi_q <= isi_q + 1'b1;
            end
         end
         if (spike && fifo_full && !pop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   izh_event_fifo #(
      .WIDTH (EV_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (spike),
      .data_i  (push_data),
      .full_o  (fifo_full),
      .pop_i   (pop),
      .data_o  (head_data),
      .empty_o (fifo_empty)
   );

   assign spike_pulse                   = pulse_q;
   assign ev_valid                      = !fifo_empty;
   assign {ev_first, ev_burst, ev_isi}  = head_data;
   assign spike_count                   = count_q;
   assign overflow                      = ovf_q;

endmodule
